// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  localparam int LOADER_HDR_BYTES = 2;

  typedef logic [31:0] loader_word_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte stream into instruction memory
// and holds the core in reset until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH          = 128,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_hold
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  loader_state_t    state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [15:0]      count_q, count_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  loader_word_t     wdata_q, wdata_d;
  logic [TO_W-1:0]  idle_q, idle_d;

  logic        xfer;
  logic [15:0] hdr_n;

  assign rx_ready   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign busy       = rx_ready || (state_q == WRITE);
  assign imem_we    = (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign core_hold  = (state_q != DONE);
  assign imem_addr  = ADDR_W'({word_idx_q, 2'b00});
  assign imem_wdata = wdata_q;

  assign xfer  = rx_valid && rx_ready;
  assign hdr_n = {rx_data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wdata_d    = wdata_q;
    idle_d     = idle_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          word_idx_d = '0;
          byte_idx_d = '0;
          idle_d     = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          count_d = hdr_n;
          if (hdr_n == 16'd0)             state_d = DONE;
          else if (hdr_n > 16'(DEPTH))    state_d = ERR;
          else                            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          // Shift in from the top so the first byte of a word lands in [7:0].
          wdata_d    = {rx_data, wdata_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        idle_d = '0;
        // The index only advances when another word follows, keeping it below DEPTH.
        if (16'(word_idx_q) + 16'd1 < count_q) begin
          word_idx_d = word_idx_q + IDX_W'(1);
          state_d    = DATA;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_ready) begin
      if (xfer)                    idle_d = '0;
      else if (idle_q == IDLE_LAST) state_d = ERR;
      else                          idle_d = idle_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_lo_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wdata_q    <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wdata_q    <= wdata_d;
      idle_q     <= idle_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory image loader for the rvsoc baseline SoC. It accepts a byte stream from the UART receiver, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory starting at byte address 0. While loading, it holds the core in reset, and it releases the core once a complete, valid image has been written. It is the write-side counterpart of the core's read-only instruction fetch path.

## Interface
- `DEPTH`, 128 — instruction memory size in 32-bit words; maximum accepted image length.
- `ADDR_W`, 12 — width of the byte address presented to instruction memory.
- `TIMEOUT_CYCLES`, 1_000_000 — maximum idle cycles between accepted bytes during a load before it aborts.

Ports:
- `clk` — in, 1 — single system clock.
- `reset_n` — in, 1 — reset, asynchronous and active-low.
- `start` — in, 1 — single-cycle pulse that begins a load; ignored while busy.
- `rx_data` — in, 8 — received byte.
- `rx_valid` — in, 1 — `rx_data` is valid.
- `rx_ready` — out, 1 — loader can accept a byte; a transfer occurs on `rx_valid && rx_ready`.
- `imem_we` — out, 1 — single-cycle write strobe to instruction memory.
- `imem_addr` — out, ADDR_W — word-aligned byte address (bits [1:0] always 0).
- `imem_wdata` — out, 32 — assembled instruction word.
- `busy` — out, 1 — a load is in progress.
- `done` — out, 1 — last load completed successfully (sticky until the next `start`).
- `error` — out, 1 — last load aborted (sticky until the next `start`).
- `core_hold` — out, 1 — holds the core in reset.

## Operation
- Image format: 2-byte word count N (low byte first), then 4·N data bytes. Each word is little-endian: the first byte of a word goes to [7:0].
- States:
  - IDLE: waits for `start`.
  - LEN_LO: accepts the count low byte.
  - LEN_HI: accepts the count high byte.
  - DATA: accepts data bytes.
  - WRITE: issues the memory write.
  - DONE: load finished successfully.
  - ERR: load aborted.
- Transitions:
  - IDLE/DONE/ERR → LEN_LO on `start`; this clears `done`, `error`, the word index and the byte index.
  - LEN_LO → LEN_HI on transfer.
  - LEN_HI on transfer:
    - N == 0 → DONE.
    - N > DEPTH → ERR.
    - otherwise → DATA.
  - DATA → WRITE on the 4th byte of a word; the byte index wraps 3 → 0.
  - WRITE → DATA if word_idx+1 < N, else → DONE. word_idx increments in WRITE.
  - Any of LEN_LO/LEN_HI/DATA → ERR when the idle counter reaches TIMEOUT_CYCLES−1 with no transfer. The counter clears on every transfer and on `start`.
- `rx_ready` = 1 only in LEN_LO, LEN_HI and DATA; it is 0 in WRITE.
- `imem_addr` = word_idx << 2, truncated to ADDR_W. Word_idx never exceeds DEPTH−1, so addresses never wrap.
- `core_hold` = 1 in every state except DONE. It is 1 out of reset, so the core never runs from unloaded memory.
- `busy` = 1 in LEN_LO, LEN_HI, DATA and WRITE.
- `start` asserted while busy is ignored; the load continues unchanged.
- Words already written before an abort stay in memory. `error` marks the whole image as invalid.

## Timing
- Reset values:
  - state = IDLE
  - `rx_ready` = 0
  - `imem_we` = 0
  - `imem_addr` = 0
  - `imem_wdata` = 0
  - `busy` = 0
  - `done` = 0
  - `error` = 0
  - `core_hold` = 1
- `start` sampled in cycle t gives LEN_LO and `rx_ready` = 1 in cycle t+1.
- The 4th byte of a word is accepted in cycle t; in cycle t+1 `imem_we` = 1 with stable addr/wdata; `rx_ready` returns in t+2. Throughput is at most one word per 5 cycles, far above UART rates.
- `done`/`core_hold` update one cycle after the final WRITE cycle, or one cycle after LEN_HI when N = 0.
- All outputs are registered or decoded from state only; there are no combinational paths from `rx_*` to outputs.
- Asserting `reset_n` mid-load aborts immediately to the reset values, with no partial write. A write in flight completes only if its WRITE cycle precedes reset assertion.

## Structure
- `imem_loader_pkg`: state enum `loader_state_t` (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR), constant `LOADER_HDR_BYTES` = 2, and `loader_word_t` (32-bit).
- Single module, with no sub-module. The byte assembler, word/byte counters and timeout counter are small and state-coupled.
- The timeout counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Reset then `start`, stream 02 00 13 00 00 00 B7 05 00 20 → writes 0x00000013 @0x000 and 0x200005B7 @0x004; `done` = 1, `core_hold` = 0, exactly 2 `imem_we` pulses.
- Count bytes 00 00 → DONE one cycle after LEN_HI, no writes, `core_hold` = 0.
- Count 0x0081 (129 > DEPTH) → ERR, `error` = 1, `core_hold` = 1, `rx_ready` = 0, no writes.
- With TIMEOUT_CYCLES = 16, send count 01 00 and 2 data bytes, then stall → ERR after 16 idle cycles; a new `start` clears `error`, and a full reload succeeds.
- `rx_valid` held high continuously → `rx_ready` drops for exactly one cycle per word; no byte is lost or duplicated over a 128-word image; the last address is 0x1FC.
- Assert `reset_n` low mid-word (after 2 data bytes) → all outputs return to reset values at once, no `imem_we`; `start` pulsed while busy has no effect.
